ws2812_rx: RTL and testbench



---
 rtl/ws2812_rx.sv | 221 ++++++++++++++++++++++
 tb/tb_ws2812_rx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_rx.sv
// WS2812 single-wire receiver: decodes NeoPixel pulses into 24-bit AXI-Stream beats.
// Optional daisy-chain forwarding is enabled by defining WS2812_RX_FORWARD_EN.
module ws2812_rx #(
  parameter int unsigned HIGH_THRESH  = 43,
  parameter int unsigned MIN_HIGH     = 7,
  parameter int unsigned MAX_HIGH     = 108,
  parameter int unsigned RESET_CYCLES = 3600
) (
  input  logic        axis_aclk,
  input  logic        axis_resetn,
  input  logic        i_serial,
  output logic [23:0] m_axis_data,
  output logic        m_axis_valid,
  input  logic        m_axis_ready,
  output logic        o_frame_done,
  output logic [15:0] o_pixel_count,
  output logic        o_err,
  output logic        o_overrun,
  output logic        o_serial,
  output logic [3:0]  o_debug
);

`ifdef WS2812_RX_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  localparam logic [7:0]  THRESH_C   = 8'(HIGH_THRESH);
  localparam logic [7:0]  MIN_C      = 8'(MIN_HIGH);
  localparam logic [7:0]  MAX_C      = 8'(MAX_HIGH);
  localparam logic [15:0] LOW_LAST_C = 16'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_IDLE = 2'd1,
    S_HIGH = 2'd2,
    S_LOW  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        rx_m, rx_s;
  logic [7:0]  high_cnt_q, high_cnt_d;
  logic [15:0] low_cnt_q, low_cnt_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [23:0] shift_q, shift_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] pixel_count_q, pixel_count_d;
  logic        pix_done_q, pix_done_d;
  logic        pix_emit_q, pix_emit_d;
  logic        fwd_q, fwd_d;
  logic        err_q, err_d;
  logic        frame_done_q, frame_done_d;
  logic [23:0] data_q;
  logic        valid_q;
  logic        overrun_q;
  logic        serial_q;

  // Two-flop synchronizer; nothing downstream looks at i_serial directly.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      rx_m <= 1'b0;
      rx_s <= 1'b0;
    end else begin
      rx_m <= i_serial;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q       <= S_SYNC;
      high_cnt_q    <= '0;
      low_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      frame_cnt_q   <= '0;
      pixel_count_q <= '0;
      pix_done_q    <= 1'b0;
      pix_emit_q    <= 1'b0;
      fwd_q         <= 1'b0;
      err_q         <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      high_cnt_q    <= high_cnt_d;
      low_cnt_q     <= low_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      frame_cnt_q   <= frame_cnt_d;
      pixel_count_q <= pixel_count_d;
      pix_done_q    <= pix_done_d;
      pix_emit_q    <= pix_emit_d;
      fwd_q         <= fwd_d;
      err_q         <= err_d;
      frame_done_q  <= frame_done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    high_cnt_d    = high_cnt_q;
    low_cnt_d     = low_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    frame_cnt_d   = frame_cnt_q;
    pixel_count_d = pixel_count_q;
    fwd_d         = fwd_q;
    pix_done_d    = 1'b0;
    pix_emit_d    = 1'b0;
    err_d         = 1'b0;
    frame_done_d  = 1'b0;
    case (state_q)
      S_SYNC: begin
        fwd_d = 1'b0;
        if (rx_s) begin
          low_cnt_d = '0;
        end else if (low_cnt_q >= LOW_LAST_C) begin
          low_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          low_cnt_d = low_cnt_q + 16'd1;
        end
      end
      S_IDLE: begin
        if (rx_s) begin
          low_cnt_d   = '0;
          bit_cnt_d   = '0;
          frame_cnt_d = '0;
          high_cnt_d  = 8'd1;
          state_d     = S_HIGH;
        end
      end
      S_HIGH: begin
        if (rx_s) begin
          if (high_cnt_q >= MAX_C) begin
            err_d     = 1'b1;
            low_cnt_d = '0;
            state_d   = S_SYNC;
          end else if (high_cnt_q != 8'hFF) begin
            high_cnt_d = high_cnt_q + 8'd1;
          end
        end else begin
          // The low counter starts after the edge-detect cycle, which puts
          // end-of-frame at RESET_CYCLES + 3 clocks after the pin falls.
          low_cnt_d = '0;
          state_d   = S_LOW;
          if (high_cnt_q < MIN_C) begin
            state_d = S_LOW;
          end else if (high_cnt_q > MAX_C) begin
            err_d   = 1'b1;
            state_d = S_SYNC;
          end else begin
            shift_d = {shift_q[22:0], (high_cnt_q >= THRESH_C)};
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_d  = '0;
              pix_done_d = 1'b1;
              pix_emit_d = !FWD_EN || (frame_cnt_q == 16'd0);
              fwd_d      = FWD_EN;
              if (frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end
      end
      S_LOW: begin
        if (rx_s) begin
          high_cnt_d = 8'd1;
          state_d    = S_HIGH;
        end else if (low_cnt_q >= LOW_LAST_C) begin
          frame_done_d  = 1'b1;
          pixel_count_d = frame_cnt_q;
          err_d         = (bit_cnt_q != 5'd0);
          bit_cnt_d     = '0;
          fwd_d         = 1'b0;
          low_cnt_d     = '0;
          state_d       = S_IDLE;
        end else if (low_cnt_q != 16'hFFFF) begin
          low_cnt_d = low_cnt_q + 16'd1;
        end
      end
      default: state_d = S_SYNC;
    endcase
  end

  // Output handshake: a beat transfers on any clock where m_axis_valid and
  // m_axis_ready are both high; once raised, valid and data hold until that
  // transfer. A pixel arriving while a beat is stalled is dropped (overrun);
  // one arriving on the accepting clock replaces the outgoing beat.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      serial_q  <= 1'b0;
    end else begin
      serial_q <= FWD_EN && fwd_q && rx_s;
      if (pix_done_q && pix_emit_q) begin
        if (valid_q && !m_axis_ready) begin
          overrun_q <= 1'b1;
        end else begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end
      end else if (m_axis_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign m_axis_data   = data_q;
  assign m_axis_valid  = valid_q;
  assign o_frame_done  = frame_done_q;
  assign o_pixel_count = pixel_count_q;
  assign o_err         = err_q;
  assign o_overrun     = overrun_q;
  assign o_serial      = serial_q;
  assign o_debug       = {valid_q, rx_s, state_q};

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed testbench for ws2812_rx: sendPx-timed pixels, overrun, glitch,
// partial pixel, long-pulse error recovery and mid-frame reset.
module tb_ws2812_rx;

  localparam int RESET_CYCLES = 3600;

  logic        clk;
  logic        rst_n;
  logic        i_serial;
  logic [23:0] m_axis_data;
  logic        m_axis_valid;
  logic        m_axis_ready;
  logic        o_frame_done;
  logic [15:0] o_pixel_count;
  logic        o_err;
  logic        o_overrun;
  logic        o_serial;
  logic [3:0]  o_debug;

  int n_checks = 0;
  int n_errors = 0;
  int err_cnt  = 0;
  int fd_cnt   = 0;
  logic [23:0] exp_q[$];
  logic [23:0] got_q[$];

  ws2812_rx dut (
    .axis_aclk     (clk),
    .axis_resetn   (rst_n),
    .i_serial      (i_serial),
    .m_axis_data   (m_axis_data),
    .m_axis_valid  (m_axis_valid),
    .m_axis_ready  (m_axis_ready),
    .o_frame_done  (o_frame_done),
    .o_pixel_count (o_pixel_count),
    .o_err         (o_err),
    .o_overrun     (o_overrun),
    .o_serial      (o_serial),
    .o_debug       (o_debug)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor: transfers and pulse counts
  always @(posedge clk) begin
    if (rst_n) begin
      if (m_axis_valid && m_axis_ready) got_q.push_back(m_axis_data);
      if (o_err) err_cnt++;
      if (o_frame_done) fd_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: compare received beats against the expected queue, in order
  task automatic check_beats(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_data"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
  endtask

  // driver tasks (called at a negedge, return at a negedge)
  task automatic send_bit(input logic b);
    i_serial = 1'b1;
    repeat (b ? 58 : 29) @(negedge clk);
    i_serial = 1'b0;
    repeat (b ? 32 : 61) @(negedge clk);
  endtask

  task automatic send_px(input logic [23:0] d);
    for (int i = 23; i >= 0; i--) send_bit(d[i]);
  endtask

  task automatic gap(input int n);
    i_serial = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int err_base;
    int fd_base;
    logic [23:0] px;

    rst_n = 1'b0;
    i_serial = 1'b0;
    m_axis_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(m_axis_valid), 32'd0);
    check("rst_data", 32'(m_axis_data), 32'd0);
    check("rst_count", 32'(o_pixel_count), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_overrun", 32'(o_overrun), 32'd0);
    check("rst_serial", 32'(o_serial), 32'd0);
    check("rst_frame_done", 32'(o_frame_done), 32'd0);
    check("rst_state", 32'(o_debug[1:0]), 32'd0);
    rst_n = 1'b1;

    gap(3700);
    check("sync_to_idle", 32'(o_debug[1:0]), 32'd1);

    // single pixel 0x00FF00: latency and end-of-frame timing
    px = 24'h00FF00;
    for (int i = 23; i >= 1; i--) send_bit(px[i]);
    i_serial = 1'b1;
    repeat (29) @(negedge clk);
    i_serial = 1'b0;
    repeat (3) @(negedge clk);
    check("lat_valid_early", 32'(m_axis_valid), 32'd0);
    @(negedge clk);
    check("lat_valid_4", 32'(m_axis_valid), 32'd1);
    check("px1_data", 32'(m_axis_data), 32'h00FF00);
    repeat (RESET_CYCLES - 2) @(negedge clk);
    check("fd_early", 32'(o_frame_done), 32'd0);
    @(negedge clk);
    check("fd_pulse", 32'(o_frame_done), 32'd1);
    check("px1_count", 32'(o_pixel_count), 32'd1);
    @(negedge clk);
    check("fd_one_cycle", 32'(o_frame_done), 32'd0);
    check("px1_data_held", 32'(m_axis_data), 32'h00FF00);
    m_axis_ready = 1'b1;
    @(negedge clk);
    check("px1_accepted", 32'(m_axis_valid), 32'd0);
    exp_q.push_back(24'h00FF00);
    check_beats("px1_beat");
    check("px1_no_err", 32'(err_cnt), 32'd0);
    gap(700);

    // eight pixels back to back, ready held high
    fd_base = fd_cnt;
    for (int p = 0; p < 8; p++) begin
      send_px(24'(p));
      exp_q.push_back(24'(p));
    end
    gap(3700);
    check_beats("burst");
    check("burst_count", 32'(o_pixel_count), 32'd8);
    check("burst_no_err", 32'(err_cnt), 32'd0);
    check("burst_fd", 32'(fd_cnt - fd_base), 32'd1);
    check("burst_no_overrun", 32'(o_overrun), 32'd0);

    // stalled sink: second pixel is dropped, first is held
    m_axis_ready = 1'b0;
    send_px(24'hAAAAAA);
    check("ovr_first_valid", 32'(m_axis_valid), 32'd1);
    check("ovr_first_clean", 32'(o_overrun), 32'd0);
    send_px(24'h555555);
    check("ovr_held_data", 32'(m_axis_data), 32'hAAAAAA);
    check("ovr_flag", 32'(o_overrun), 32'd1);
    check("ovr_no_beat", 32'(got_q.size()), 32'd0);
    m_axis_ready = 1'b1;
    @(negedge clk);
    check("ovr_drained", 32'(m_axis_valid), 32'd0);
    gap(3700);
    exp_q.push_back(24'hAAAAAA);
    check_beats("ovr_beat");
    check("ovr_count", 32'(o_pixel_count), 32'd2);

    // glitch between bits plus a trailing 12-bit partial pixel
    err_base = err_cnt;
    px = 24'h123456;
    for (int i = 23; i >= 0; i--) begin
      send_bit(px[i]);
      if (i == 12) begin
        i_serial = 1'b1;
        repeat (3) @(negedge clk);
        i_serial = 1'b0;
        repeat (20) @(negedge clk);
      end
    end
    for (int i = 0; i < 12; i++) send_bit(1'b1);
    gap(3700);
    exp_q.push_back(24'h123456);
    check_beats("glitch_beat");
    check("partial_err", 32'(err_cnt - err_base), 32'd1);
    check("partial_count", 32'(o_pixel_count), 32'd1);

    // over-long high pulse: error, resync, next pixel ignored
    err_base = err_cnt;
    fd_base = fd_cnt;
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    i_serial = 1'b1;
    repeat (200) @(negedge clk);
    check("long_err", 32'(err_cnt - err_base), 32'd1);
    check("long_state_sync", 32'(o_debug[1:0]), 32'd0);
    i_serial = 1'b0;
    repeat (40) @(negedge clk);
    send_px(24'h0F0F0F);
    check("long_ignored_state", 32'(o_debug[1:0]), 32'd0);
    gap(3700);
    check("long_resync_idle", 32'(o_debug[1:0]), 32'd1);
    check_beats("long_ignored");
    check("long_single_err", 32'(err_cnt - err_base), 32'd1);
    check("long_no_fd", 32'(fd_cnt - fd_base), 32'd0);
    send_px(24'h0000FF);
    send_px(24'hC0FFEE);
    gap(3700);
    exp_q.push_back(24'h0000FF);
    exp_q.push_back(24'hC0FFEE);
    check_beats("recover");
    check("recover_count", 32'(o_pixel_count), 32'd2);
    check("serial_off", 32'(o_serial), 32'd0);

    // reset mid-pixel clears everything, including the sticky overrun
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    i_serial = 1'b1;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_state", 32'(o_debug[1:0]), 32'd0);
    check("midrst_overrun", 32'(o_overrun), 32'd0);
    check("midrst_count", 32'(o_pixel_count), 32'd0);
    check("midrst_valid", 32'(m_axis_valid), 32'd0);
    i_serial = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
